// File: rtl/odd_wb_pipe.sv
// Variable-latency result pipeline for the odd execution pipe.
// Packets are inserted at the stage that puts them on the single writeback
// port exactly Le cycles after acceptance. Writeback-slot conflicts are
// resolved at issue. A flush drops young entries by age. Every stage is
// exposed as a forwarding tap.
module odd_wb_pipe #(
    parameter int DATA_W    = 128,
    parameter int ADDR_W    = 7,
    parameter int PC_W      = 32,
    parameter int UNIT_W    = 3,
    parameter int DEPTH     = 7,
    parameter int LAT_W     = $clog2(DEPTH + 1),
    parameter int FLUSH_AGE = 3,
    parameter int CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [UNIT_W-1:0]        in_unit,
    input  logic [LAT_W-1:0]         in_lat,
    input  logic                     in_wr_en,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [PC_W-1:0]          in_pc,
    input  logic                     in_br,
    input  logic                     flush,
    output logic                     wb_valid,
    output logic [UNIT_W-1:0]        wb_unit,
    output logic                     wb_wr_en,
    output logic [ADDR_W-1:0]        wb_addr,
    output logic [DATA_W-1:0]        wb_data,
    output logic [PC_W-1:0]          wb_pc,
    output logic                     wb_br,
    output logic [DEPTH-1:0]         fwd_valid,
    output logic [DEPTH*ADDR_W-1:0]  fwd_addr,
    output logic [DEPTH*DATA_W-1:0]  fwd_data,
    output logic [LAT_W-1:0]         occupancy,
    output logic [CNT_W-1:0]         stall_cnt
);

    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [DEPTH-1:0][LAT_W-1:0]  age_q, age_d;
    logic [DEPTH-1:0][UNIT_W-1:0] unit_q, unit_d;
    logic [DEPTH-1:0]             wr_en_q, wr_en_d;
    logic [DEPTH-1:0][ADDR_W-1:0] addr_q, addr_d;
    logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
    logic [DEPTH-1:0][PC_W-1:0]   pc_q, pc_d;
    logic [DEPTH-1:0]             br_q, br_d;
    logic [CNT_W-1:0]             stall_cnt_q, stall_cnt_d;

    logic [LAT_W-1:0]             lat_eff;
    int                           ins_idx;
    logic                         conflict;
    logic                         accept;
    logic                         ready;

    // Clamp the requested latency and find the insertion stage and whether
    // the stage feeding it is occupied (its packet would land there too).
    always_comb begin
        lat_eff  = in_lat;
        conflict = 1'b0;
        if (in_lat == '0) begin
            lat_eff = LAT_W'(1);
        end else if (int'(in_lat) > DEPTH) begin
            lat_eff = LAT_W'(DEPTH);
        end
        ins_idx = DEPTH - int'(lat_eff);
        for (int k = 0; k < DEPTH; k++) begin
            if ((k == ins_idx - 1) && valid_q[k]) begin
                conflict = 1'b1;
            end
        end
        ready  = !flush && !conflict;
        accept = in_valid && ready;
    end

    // Shift every stage forward one slot, drop young entries on flush and
    // overwrite the insertion stage with the accepted packet.
    always_comb begin
        valid_d  = '0;
        age_d    = '0;
        unit_d   = '0;
        wr_en_d  = '0;
        addr_d   = '0;
        data_d   = '0;
        pc_d     = '0;
        br_d     = '0;
        for (int k = 1; k < DEPTH; k++) begin
            valid_d[k] = valid_q[k-1] &&
                         !(flush && (int'(age_q[k-1]) < FLUSH_AGE));
            age_d[k]   = age_q[k-1] + LAT_W'(1);
            unit_d[k]  = unit_q[k-1];
            wr_en_d[k] = wr_en_q[k-1];
            addr_d[k]  = addr_q[k-1];
            data_d[k]  = data_q[k-1];
            pc_d[k]    = pc_q[k-1];
            br_d[k]    = br_q[k-1];
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (accept && (k == ins_idx)) begin
                valid_d[k] = 1'b1;
                age_d[k]   = '0;
                unit_d[k]  = in_unit;
                wr_en_d[k] = in_wr_en;
                addr_d[k]  = in_addr;
                data_d[k]  = in_data;
                pc_d[k]    = in_pc;
                br_d[k]    = in_br;
            end
        end
    end

    // Count cycles where a packet was refused for a slot conflict, saturating.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (in_valid && !ready && !flush && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Stage and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q     <= '0;
            age_q       <= '0;
            unit_q      <= '0;
            wr_en_q     <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            pc_q        <= '0;
            br_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            age_q       <= age_d;
            unit_q      <= unit_d;
            wr_en_q     <= wr_en_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            pc_q        <= pc_d;
            br_q        <= br_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Population count of the registered stages.
    always_comb begin
        occupancy = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occupancy = occupancy + LAT_W'(valid_q[k]);
        end
    end

    assign in_ready  = ready;
    assign wb_valid  = valid_q[DEPTH-1];
    assign wb_unit   = unit_q[DEPTH-1];
    assign wb_wr_en  = wr_en_q[DEPTH-1];
    assign wb_addr   = addr_q[DEPTH-1];
    assign wb_data   = data_q[DEPTH-1];
    assign wb_pc     = pc_q[DEPTH-1];
    assign wb_br     = br_q[DEPTH-1];
    assign fwd_valid = valid_q & wr_en_q;
    assign fwd_addr  = addr_q;
    assign fwd_data  = data_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_odd_wb_pipe.sv
// Directed testbench for odd_wb_pipe with DEPTH=7 and FLUSH_AGE=3.
module tb_odd_wb_pipe;

    localparam int DATA_W    = 128;
    localparam int ADDR_W    = 7;
    localparam int PC_W      = 32;
    localparam int UNIT_W    = 3;
    localparam int DEPTH     = 7;
    localparam int LAT_W     = $clog2(DEPTH + 1);
    localparam int FLUSH_AGE = 3;
    localparam int CNT_W     = 16;

    logic                    clk;
    logic                    reset;
    logic                    inValid;
    logic                    inReady;
    logic [UNIT_W-1:0]       inUnit;
    logic [LAT_W-1:0]        inLat;
    logic                    inWrEn;
    logic [ADDR_W-1:0]       inAddr;
    logic [DATA_W-1:0]       inData;
    logic [PC_W-1:0]         inPc;
    logic                    inBr;
    logic                    flush;
    logic                    wbValid;
    logic [UNIT_W-1:0]       wbUnit;
    logic                    wbWrEn;
    logic [ADDR_W-1:0]       wbAddr;
    logic [DATA_W-1:0]       wbData;
    logic [PC_W-1:0]         wbPc;
    logic                    wbBr;
    logic [DEPTH-1:0]        fwdValid;
    logic [DEPTH*ADDR_W-1:0] fwdAddr;
    logic [DEPTH*DATA_W-1:0] fwdData;
    logic [LAT_W-1:0]        occupancy;
    logic [CNT_W-1:0]        stallCnt;

    int testsRun;
    int testsFailed;

    odd_wb_pipe #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W), .UNIT_W(UNIT_W),
        .DEPTH(DEPTH), .LAT_W(LAT_W), .FLUSH_AGE(FLUSH_AGE), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(inValid), .in_ready(inReady), .in_unit(inUnit),
        .in_lat(inLat), .in_wr_en(inWrEn), .in_addr(inAddr),
        .in_data(inData), .in_pc(inPc), .in_br(inBr), .flush(flush),
        .wb_valid(wbValid), .wb_unit(wbUnit), .wb_wr_en(wbWrEn),
        .wb_addr(wbAddr), .wb_data(wbData), .wb_pc(wbPc), .wb_br(wbBr),
        .fwd_valid(fwdValid), .fwd_addr(fwdAddr), .fwd_data(fwdData),
        .occupancy(occupancy), .stall_cnt(stallCnt)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input int lat,
                                 input int addr, input logic [DATA_W-1:0] data);
        inValid = v;
        inLat   = LAT_W'(lat);
        inAddr  = ADDR_W'(addr);
        inData  = data;
        inUnit  = UNIT_W'(addr);
        inWrEn  = 1'b1;
        inPc    = PC_W'(addr) << 2;
        inBr    = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b0;
        flush = 1'b0;
        applyStimulus(1'b0, 0, 0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        flush = 1'b0;
        applyStimulus(1'b0, 0, 0, '0);
        #12;
        testsRun++;
        if (wbValid !== 1'b0 || occupancy !== '0 || stallCnt !== '0 ||
            fwdValid !== '0 || wbData !== '0 || wbAddr !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_state: wb_valid=%0b occ=%0d stall=%0d fwd_valid=%0h expected all 0",
                     wbValid, occupancy, stallCnt, fwdValid);
        end
        doReset();
    endtask

    task automatic test_latency_one();
        logic [DATA_W-1:0] pat;
        pat = {16{8'hA5}};
        doReset();
        applyStimulus(1'b1, 1, 5, pat);
        #1;
        testsRun++;
        if (inReady !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL l1_ready: got %0b expected 1", inReady);
        end
        tick();
        applyStimulus(1'b0, 0, 0, '0);
        testsRun++;
        if (wbValid !== 1'b1 || wbAddr !== 7'd5 || wbData !== pat || occupancy !== 3'd1) begin
            testsFailed++;
            $display("[TB] FAIL l1_wb: valid=%0b addr=%0d data=%0h occ=%0d expected 1/5/%0h/1",
                     wbValid, wbAddr, wbData, occupancy, pat);
        end
        tick();
        testsRun++;
        if (wbValid !== 1'b0 || occupancy !== 3'd0) begin
            testsFailed++;
            $display("[TB] FAIL l1_retire: valid=%0b occ=%0d expected 0/0", wbValid, occupancy);
        end
    endtask

    task automatic test_hazard();
        doReset();
        applyStimulus(1'b1, 4, 1, 128'h44);
        tick();
        applyStimulus(1'b1, 3, 2, 128'h33);
        #1;
        testsRun++;
        if (inReady !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL hazard_ready: got %0b expected 0", inReady);
        end
        tick();
        testsRun++;
        if (stallCnt !== 16'd1 || wbValid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL hazard_stall: stall=%0d wb_valid=%0b expected 1/0", stallCnt, wbValid);
        end
        #1;
        testsRun++;
        if (inReady !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL hazard_reoffer: got %0b expected 1", inReady);
        end
        tick();
        applyStimulus(1'b0, 0, 0, '0);
        testsRun++;
        if (wbValid !== 1'b0 || occupancy !== 3'd2 || stallCnt !== 16'd1) begin
            testsFailed++;
            $display("[TB] FAIL hazard_edge2: valid=%0b occ=%0d stall=%0d expected 0/2/1",
                     wbValid, occupancy, stallCnt);
        end
        tick();
        testsRun++;
        if (wbValid !== 1'b1 || wbAddr !== 7'd1 || wbData !== 128'h44) begin
            testsFailed++;
            $display("[TB] FAIL hazard_l4_wb: valid=%0b addr=%0d data=%0h expected 1/1/44",
                     wbValid, wbAddr, wbData);
        end
        tick();
        testsRun++;
        if (wbValid !== 1'b1 || wbAddr !== 7'd2 || wbData !== 128'h33) begin
            testsFailed++;
            $display("[TB] FAIL hazard_l3_wb: valid=%0b addr=%0d data=%0h expected 1/2/33",
                     wbValid, wbAddr, wbData);
        end
        tick();
        testsRun++;
        if (wbValid !== 1'b0 || occupancy !== 3'd0) begin
            testsFailed++;
            $display("[TB] FAIL hazard_drain: valid=%0b occ=%0d expected 0/0", wbValid, occupancy);
        end
    endtask

    task automatic test_back_to_back();
        int maxOcc;
        int readyErrs;
        int wbErrs;
        logic expValid;
        logic [DATA_W-1:0] expData;
        maxOcc    = 0;
        readyErrs = 0;
        wbErrs    = 0;
        doReset();
        for (int cyc = 0; cyc < 18; cyc++) begin
            if (cyc < 10) begin
                applyStimulus(1'b1, 7, cyc + 16, DATA_W'(cyc));
                #1;
                if (inReady !== 1'b1) begin
                    readyErrs++;
                end
            end else begin
                applyStimulus(1'b0, 0, 0, '0);
            end
            tick();
            expValid = (cyc >= 6) && (cyc <= 15);
            expData  = expValid ? DATA_W'(cyc - 6) : '0;
            if (wbValid !== expValid || (expValid && wbData !== expData)) begin
                wbErrs++;
                $display("[TB] FAIL b2b_wb_cyc%0d: valid=%0b data=%0h expected %0b/%0h",
                         cyc, wbValid, wbData, expValid, expData);
            end
            if (int'(occupancy) > maxOcc) begin
                maxOcc = int'(occupancy);
            end
        end
        testsRun++;
        if (readyErrs != 0) begin
            testsFailed++;
            $display("[TB] FAIL b2b_ready: %0d cycles not ready expected 0", readyErrs);
        end
        testsRun++;
        if (wbErrs != 0) begin
            testsFailed++;
            $display("[TB] FAIL b2b_wb: %0d wrong cycles expected 0", wbErrs);
        end
        testsRun++;
        if (maxOcc != 7) begin
            testsFailed++;
            $display("[TB] FAIL b2b_peak_occ: got %0d expected 7", maxOcc);
        end
    endtask

    task automatic test_flush();
        int strayWb;
        strayWb = 0;
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 7, 10 + i, DATA_W'(32'hA + i));
            tick();
        end
        flush = 1'b1;
        applyStimulus(1'b1, 7, 47, 128'hFF);
        #1;
        testsRun++;
        if (inReady !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL flush_ready: got %0b expected 0", inReady);
        end
        tick();
        flush = 1'b0;
        applyStimulus(1'b0, 0, 0, '0);
        testsRun++;
        if (occupancy !== 3'd1 || stallCnt !== 16'd0 || fwdValid !== 7'b001_0000) begin
            testsFailed++;
            $display("[TB] FAIL flush_survivor: occ=%0d stall=%0d fwd_valid=%0h expected 1/0/10",
                     occupancy, stallCnt, fwdValid);
        end
        tick();
        if (wbValid !== 1'b0) strayWb++;
        tick();
        testsRun++;
        if (wbValid !== 1'b1 || wbData !== 128'hA || wbAddr !== 7'd10) begin
            testsFailed++;
            $display("[TB] FAIL flush_a_wb: valid=%0b data=%0h addr=%0d expected 1/a/10",
                     wbValid, wbData, wbAddr);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (wbValid !== 1'b0) strayWb++;
        end
        testsRun++;
        if (strayWb != 0) begin
            testsFailed++;
            $display("[TB] FAIL flush_killed: %0d stray writebacks expected 0", strayWb);
        end
    endtask

    task automatic test_latency_zero();
        doReset();
        applyStimulus(1'b1, 0, 9, 128'h99);
        tick();
        applyStimulus(1'b0, 0, 0, '0);
        testsRun++;
        if (wbValid !== 1'b1 || wbAddr !== 7'd9 || wbData !== 128'h99) begin
            testsFailed++;
            $display("[TB] FAIL lat0_wb: valid=%0b addr=%0d data=%0h expected 1/9/99",
                     wbValid, wbAddr, wbData);
        end
    endtask

    task automatic test_midreset();
        int strayWb;
        strayWb = 0;
        doReset();
        applyStimulus(1'b1, 7, 3, 128'h3);
        tick();
        applyStimulus(1'b1, 7, 4, 128'h4);
        tick();
        applyStimulus(1'b1, 1, 6, 128'h6);
        tick();
        applyStimulus(1'b0, 0, 0, '0);
        testsRun++;
        if (wbValid !== 1'b1 || occupancy !== 3'd3) begin
            testsFailed++;
            $display("[TB] FAIL midreset_pre: valid=%0b occ=%0d expected 1/3", wbValid, occupancy);
        end
        #2;
        reset = 1'b0;
        #1;
        testsRun++;
        if (wbValid !== 1'b0 || occupancy !== '0 || fwdValid !== '0 ||
            wbData !== '0 || wbAddr !== '0 || fwdData !== '0) begin
            testsFailed++;
            $display("[TB] FAIL midreset_clear: valid=%0b occ=%0d fwd_valid=%0h data=%0h expected all 0",
                     wbValid, occupancy, fwdValid, wbData);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (wbValid !== 1'b0 || occupancy !== '0) strayWb++;
        end
        testsRun++;
        if (strayWb != 0) begin
            testsFailed++;
            $display("[TB] FAIL midreset_idle: %0d busy cycles expected 0", strayWb);
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        testsRun    = 0;
        testsFailed = 0;
        test_reset();
        test_latency_one();
        test_hazard();
        test_back_to_back();
        test_flush();
        test_latency_zero();
        test_midreset();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
